// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access sequencer:
// size codes, FSM state encoding, lane widths and the alignment check.
package mem_access_ctrl_pkg;

  localparam int unsigned BITS_SIZE      = 32;
  localparam int unsigned ADDR_BITS      = 10;
  localparam int unsigned HW_BITS        = 16;
  localparam int unsigned BYTE_BITS_SIZE = 8;

  localparam logic [1:0] SIZE_WORD    = 2'b00;
  localparam logic [1:0] SIZE_BYTE    = 2'b01;
  localparam logic [1:0] SIZE_HALF    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_RMW_WAIT  = 2'b10,
    ST_RMW_WRITE = 2'b11
  } state_e;

  // True when the request cannot be served on a word-wide RAM
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_WORD: return (offset != 2'b00);
      SIZE_HALF: return offset[0];
      SIZE_BYTE: return 1'b0;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_merge.sv
// Combinational lane insert for sub-word stores.
//   rdata  : word read from RAM
//   wdata  : store data, sub-word value in the low bits
//   size   : SIZE_BYTE / SIZE_HALF (anything else passes rdata through)
//   offset : byte offset inside the word (little-endian lanes)
//   merged : rdata with the addressed lane(s) replaced
module mem_access_ctrl_store_merge
  import mem_access_ctrl_pkg::*;
(
  input  logic [BITS_SIZE-1:0] rdata,
  input  logic [HW_BITS-1:0]   wdata,
  input  logic [1:0]           size,
  input  logic [1:0]           offset,
  output logic [BITS_SIZE-1:0] merged
);

  // Only the selected lane changes; every other bit keeps the read value
  always_comb begin
    merged = rdata;
    case (size)
      SIZE_BYTE: merged[BYTE_BITS_SIZE*32'(offset) +: BYTE_BITS_SIZE] = wdata[BYTE_BITS_SIZE-1:0];
      SIZE_HALF: merged[HW_BITS*32'(offset[1]) +: HW_BITS]            = wdata;
      default:   merged = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Turns EX/MEM load/store requests into accesses on a word-wide RAM with a
// one-cycle synchronous read. Loads take one stall cycle, sub-word stores are
// read-modify-write with two stall cycles, word stores complete immediately.
// Ports:
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_exmem_*              : request from EX/MEM (read/write/addr/wdata/size/zero_extend)
//   o_mem_addr/we/wdata    : RAM word address, write enable, write data
//   i_mem_rdata            : RAM read data, valid one cycle after the address
//   o_stall                : pipeline freeze while an access is in flight
//   o_load_valid/data      : lane-aligned load word for the writeback filter
//   o_size_filterL         : size code forwarded to the load filter
//   o_zero_extend          : extension control forwarded to the load filter
//   o_misaligned           : one-cycle error pulse on an unservable request
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_exmem_mem_read,
  input  logic                 i_exmem_mem_write,
  input  logic [BITS_SIZE-1:0] i_exmem_addr,
  input  logic [BITS_SIZE-1:0] i_exmem_wdata,
  input  logic [1:0]           i_exmem_size,
  input  logic                 i_exmem_zero_extend,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic                 o_mem_we,
  output logic [BITS_SIZE-1:0] o_mem_wdata,
  input  logic [BITS_SIZE-1:0] i_mem_rdata,
  output logic                 o_stall,
  output logic                 o_load_valid,
  output logic [BITS_SIZE-1:0] o_load_data,
  output logic [1:0]           o_size_filterL,
  output logic                 o_zero_extend,
  output logic                 o_misaligned
);

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [1:0]            offset_q;
  logic [HW_BITS-1:0]    wdata_q;
  logic [1:0]            size_q;
  logic                  zero_extend_q;
  logic [BITS_SIZE-1:0]  merged_q;
  logic [BITS_SIZE-1:0]  merged;

  logic [ADDR_BITS-1:0]  req_word_addr;
  logic [1:0]            req_offset;
  logic                  req_any;
  logic                  req_bad;
  logic                  accept;

  // Byte-address bits above the RAM word address are not decoded
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_exmem_addr[BITS_SIZE-1:ADDR_BITS+2];

  assign req_word_addr = i_exmem_addr[ADDR_BITS+1:2];
  assign req_offset    = i_exmem_addr[1:0];
  assign req_any       = i_exmem_mem_read | i_exmem_mem_write;
  assign req_bad       = is_misaligned(i_exmem_size, req_offset);
  assign accept        = (state_q == ST_IDLE) && req_any && !req_bad && !i_reset;

  mem_access_ctrl_store_merge u_store_merge (
    .rdata  (i_mem_rdata),
    .wdata  (wdata_q),
    .size   (size_q),
    .offset (offset_q),
    .merged (merged)
  );

  // State, latched request and merged store word
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      offset_q      <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      zero_extend_q <= 1'b0;
      merged_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q        <= req_word_addr;
        offset_q      <= req_offset;
        wdata_q       <= i_exmem_wdata[HW_BITS-1:0];
        size_q        <= i_exmem_size;
        zero_extend_q <= i_exmem_zero_extend;
      end
      if (state_q == ST_RMW_WAIT) begin
        merged_q <= merged;
      end
    end
  end

  // Next state and outputs; reset forces every output low so an aborted
  // read-modify-write can never reach the RAM
  always_comb begin
    state_d        = state_q;
    o_mem_addr     = '0;
    o_mem_we       = 1'b0;
    o_mem_wdata    = '0;
    o_stall        = 1'b0;
    o_load_valid   = 1'b0;
    o_load_data    = '0;
    o_size_filterL = 2'b00;
    o_zero_extend  = 1'b0;
    o_misaligned   = 1'b0;

    if (!i_reset) begin
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            if (req_bad) begin
              o_misaligned = 1'b1;
            end else if (i_exmem_mem_write) begin
              // Write wins over a simultaneous read
              o_mem_addr = req_word_addr;
              if (i_exmem_size == SIZE_WORD) begin
                o_mem_we    = 1'b1;
                o_mem_wdata = i_exmem_wdata;
              end else begin
                o_stall = 1'b1;
                state_d = ST_RMW_WAIT;
              end
            end else begin
              o_mem_addr = req_word_addr;
              o_stall    = 1'b1;
              state_d    = ST_LOAD_WAIT;
            end
          end
        end
        ST_LOAD_WAIT: begin
          o_mem_addr     = addr_q;
          o_load_valid   = 1'b1;
          o_load_data    = i_mem_rdata >> {offset_q, 3'b000};
          o_size_filterL = size_q;
          o_zero_extend  = zero_extend_q;
          state_d        = ST_IDLE;
        end
        ST_RMW_WAIT: begin
          o_mem_addr = addr_q;
          o_stall    = 1'b1;
          state_d    = ST_RMW_WRITE;
        end
        ST_RMW_WRITE: begin
          o_mem_addr  = addr_q;
          o_mem_we    = 1'b1;
          o_mem_wdata = merged_q;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural synchronous RAM and a
// scoreboard of expected RAM writes, load results and misalignment pulses.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, zero_ext;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic        stall, load_valid, zext_o, misaligned;
  logic [31:0] load_data;
  logic [1:0]  size_f;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_exmem_mem_read    (mem_read),
    .i_exmem_mem_write   (mem_write),
    .i_exmem_addr        (addr),
    .i_exmem_wdata       (wdata),
    .i_exmem_size        (size),
    .i_exmem_zero_extend (zero_ext),
    .o_mem_addr          (mem_addr),
    .o_mem_we            (mem_we),
    .o_mem_wdata         (mem_wdata),
    .i_mem_rdata         (mem_rdata),
    .o_stall             (stall),
    .o_load_valid        (load_valid),
    .o_load_data         (load_data),
    .o_size_filterL      (size_f),
    .o_zero_extend       (zext_o),
    .o_misaligned        (misaligned)
  );

  // Synchronous-read RAM with a backdoor preload port
  logic [31:0] ram [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int          kind;   // 0 write, 1 load, 2 misaligned
    logic [9:0]  waddr;
    logic [31:0] data;
    logic [1:0]  sz;
    logic        ze;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_w(input logic [9:0] a, input logic [31:0] d);
    exp_t e; e.kind = 0; e.waddr = a; e.data = d; e.sz = 2'b00; e.ze = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_l(input logic [31:0] d, input logic [1:0] s, input logic z);
    exp_t e; e.kind = 1; e.waddr = '0; e.data = d; e.sz = s; e.ze = z;
    sb.push_back(e);
  endtask

  task automatic push_m();
    exp_t e; e.kind = 2; e.waddr = '0; e.data = '0; e.sz = 2'b00; e.ze = 1'b0;
    sb.push_back(e);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Compare an observed DUT event against the head of the scoreboard
  task automatic monitor(input string tag);
    exp_t e;
    int   kind;
    if (mem_we || load_valid || misaligned) begin
      check32({tag, "_event_expected"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        kind = misaligned ? 2 : (mem_we ? 0 : 1);
        check32({tag, "_kind"}, 32'(kind), 32'(e.kind));
        check32({tag, "_stall"}, 32'(stall), 32'd0);
        case (e.kind)
          0: begin
            check32({tag, "_waddr"}, 32'(mem_addr), 32'(e.waddr));
            check32({tag, "_wdata"}, mem_wdata, e.data);
          end
          1: begin
            check32({tag, "_ldata"}, load_data, e.data);
            check32({tag, "_lsize"}, 32'(size_f), 32'(e.sz));
            check32({tag, "_lzext"}, 32'(zext_o), 32'(e.ze));
            check32({tag, "_lwe"}, 32'(mem_we), 32'd0);
          end
          default: begin
            check32({tag, "_mwe"}, 32'(mem_we), 32'd0);
            check32({tag, "_mvalid"}, 32'(load_valid), 32'd0);
          end
        endcase
      end
    end
  endtask

  // One request, held while stalled, released after the non-stall cycle
  task automatic op(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                    input logic [31:0] d, input logic [1:0] s, input logic z, input int exp_cycles);
    int   cycles;
    logic st;
    cycles = 0;
    mem_read = rd; mem_write = wr; addr = a; wdata = d; size = s; zero_ext = z;
    do begin
      @(negedge clk);
      monitor(tag);
      st = stall;
      if (st) check32({tag, "_stall_addr"}, 32'(mem_addr), 32'(a[11:2]));
      @(posedge clk); #1;
      cycles++;
    end while (st && cycles < 10);
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; size = '0; zero_ext = 1'b0;
    check32({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    check32({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_stall"}, 32'(stall), 32'd0);
    check32({tag, "_we"}, 32'(mem_we), 32'd0);
    check32({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check32({tag, "_wdata"}, mem_wdata, 32'd0);
    check32({tag, "_lvalid"}, 32'(load_valid), 32'd0);
    check32({tag, "_ldata"}, load_data, 32'd0);
    check32({tag, "_size"}, 32'(size_f), 32'd0);
    check32({tag, "_zext"}, 32'(zext_o), 32'd0);
    check32({tag, "_mis"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0; size = '0; zero_ext = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Word store then read-back
    push_w(10'd4, 32'hDEADBEEF);
    op("wstore", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, 1);
    push_l(32'hDEADBEEF, SIZE_WORD, 1'b0);
    op("wload", 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 2);

    // Sub-word loads, data shifted down to lane 0
    preload(10'd4, 32'h80112233);
    push_l(32'h00000080, SIZE_BYTE, 1'b0);
    op("bload3", 1'b1, 1'b0, 32'h13, 32'h0, SIZE_BYTE, 1'b0, 2);
    push_l(32'h00008011, SIZE_BYTE, 1'b1);
    op("bload2", 1'b1, 1'b0, 32'h12, 32'h0, SIZE_BYTE, 1'b1, 2);
    push_l(32'h00008011, SIZE_HALF, 1'b0);
    op("hload2", 1'b1, 1'b0, 32'h12, 32'h0, SIZE_HALF, 1'b0, 2);

    // Read-modify-write stores
    preload(10'd4, 32'h11223344);
    push_w(10'd4, 32'h1122AB44);
    op("bstore1", 1'b0, 1'b1, 32'h11, 32'hFFFFFFAB, SIZE_BYTE, 1'b0, 3);
    preload(10'd4, 32'h11223344);
    push_w(10'd4, 32'hBEEF3344);
    op("hstore2", 1'b0, 1'b1, 32'h12, 32'h0000BEEF, SIZE_HALF, 1'b0, 3);
    push_w(10'd4, 32'h5AEF3344);
    op("bstore3", 1'b0, 1'b1, 32'h13, 32'hFFFFFF5A, SIZE_BYTE, 1'b0, 3);
    push_w(10'd4, 32'h5AEF3399);
    op("bstore0", 1'b0, 1'b1, 32'h10, 32'h00000099, SIZE_BYTE, 1'b0, 3);
    push_w(10'd4, 32'h5AEFCDEF);
    op("hstore0", 1'b0, 1'b1, 32'h10, 32'h1234CDEF, SIZE_HALF, 1'b0, 3);
    push_l(32'h5AEFCDEF, SIZE_WORD, 1'b0);
    op("rmw_readback", 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 2);

    // Misaligned requests: single pulse, no access, no stall
    push_m();
    op("mis_hload", 1'b1, 1'b0, 32'h11, 32'h0, SIZE_HALF, 1'b0, 1);
    push_m();
    op("mis_wstore", 1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, SIZE_WORD, 1'b0, 1);
    push_m();
    op("mis_size3", 1'b1, 1'b0, 32'h10, 32'h0, SIZE_ILLEGAL, 1'b0, 1);
    push_l(32'h5AEFCDEF, SIZE_WORD, 1'b0);
    op("mis_untouched", 1'b1, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, 2);

    // Read and write together: write wins
    push_w(10'd8, 32'h12345678);
    op("rw_both", 1'b1, 1'b1, 32'h20, 32'h12345678, SIZE_WORD, 1'b0, 1);
    push_l(32'h12345678, SIZE_WORD, 1'b0);
    op("rw_readback", 1'b1, 1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0, 2);

    // Reset while in RMW_WAIT aborts the store
    preload(10'd5, 32'hCAFEF00D);
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h14; wdata = 32'h77; size = SIZE_BYTE;
    @(negedge clk);
    check32("abort_idle_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort_in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_write = 1'b0; addr = '0; wdata = '0; size = '0;
    @(negedge clk);
    check_all_zero("abort_after");
    @(posedge clk); #1;
    push_l(32'hCAFEF00D, SIZE_WORD, 1'b0);
    op("abort_ram_intact", 1'b1, 1'b0, 32'h14, 32'h0, SIZE_WORD, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
